// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue
//   Instruction-fetch front end. It fetches sequentially ahead of decode into a
//   DEPTH-entry circular queue of {pc, instr} pairs. A redirect from execute
//   flushes the queue and discards any response still in flight, so no
//   wrong-path word ever reaches decode.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   synchronous reset, active low
//   inst_read    out  memory read request (held until inst_resp)
//   inst_addr    out  request address, word aligned
//   inst_resp    in   memory response, completes the outstanding request
//   inst_rdata   in   response instruction word
//   redirect     in   one-cycle flush-and-redirect strobe
//   redirect_pc  in   new fetch address (low two bits ignored)
//   deq_valid    out  queue head valid
//   deq_ready    in   decode accepts the head
//   deq_pc       out  head PC (0 when empty)
//   deq_instr    out  head instruction (0 when empty)
//   count        out  queue occupancy, 0..DEPTH
module inst_fetch_queue #(
    parameter int                DEPTH    = 4,
    parameter int                XLEN     = 32,
    parameter logic [XLEN-1:0]   RESET_PC = 32'h00000060
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     inst_read,
    output logic [XLEN-1:0]          inst_addr,
    input  logic                     inst_resp,
    input  logic [XLEN-1:0]          inst_rdata,
    input  logic                     redirect,
    input  logic [XLEN-1:0]          redirect_pc,
    output logic                     deq_valid,
    input  logic                     deq_ready,
    output logic [XLEN-1:0]          deq_pc,
    output logic [XLEN-1:0]          deq_instr,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]       r_state;
    logic [CW-1:0]    r_count;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [XLEN-1:0]  r_fetch_pc;
    logic [XLEN-1:0]  r_drain_addr;
    logic [XLEN-1:0]  r_pc_mem    [DEPTH];
    logic [XLEN-1:0]  r_instr_mem [DEPTH];

    logic             w_push;
    logic             w_pop;
    logic [CW-1:0]    w_count_nxt;
    logic             w_unused_pc_lsbs;

    assign w_unused_pc_lsbs = ^redirect_pc[1:0];

    // A redirect cancels both the push and the pop of its cycle.
    assign w_push = (r_state == S_REQ) && inst_resp && !redirect;
    assign w_pop  = (r_count != '0) && deq_ready && !redirect;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_count      <= '0;
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_fetch_pc   <= RESET_PC;
            r_drain_addr <= RESET_PC;
        end else if (redirect) begin
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
            case (r_state)
                S_REQ: begin
                    // A request still in flight must complete on the bus at
                    // its original address; its data is thrown away in DRAIN.
                    if (!inst_resp) begin
                        r_state      <= S_DRAIN;
                        r_drain_addr <= r_fetch_pc;
                    end else begin
                        r_state <= S_REQ;
                    end
                end
                S_DRAIN: r_state <= inst_resp ? S_REQ : S_DRAIN;
                default: r_state <= S_REQ;
            endcase
        end else begin
            r_count <= w_count_nxt;
            if (w_push) begin
                r_wr_ptr   <= r_wr_ptr + PW'(1);
                r_fetch_pc <= r_fetch_pc + XLEN'(4);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case (r_state)
                S_IDLE: begin
                    if (r_count < FULL) r_state <= S_REQ;
                end
                S_REQ: begin
                    if (inst_resp) r_state <= (w_count_nxt < FULL) ? S_REQ : S_IDLE;
                end
                S_DRAIN: begin
                    if (inst_resp) r_state <= (r_count < FULL) ? S_REQ : S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Entry storage carries no reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (rst && w_push) begin
            r_pc_mem[r_wr_ptr]    <= r_fetch_pc;
            r_instr_mem[r_wr_ptr] <= inst_rdata;
        end
    end

    assign inst_read = (r_state == S_REQ) || (r_state == S_DRAIN);
    assign inst_addr = (r_state == S_DRAIN) ? r_drain_addr : r_fetch_pc;
    assign deq_valid = (r_count != '0);
    assign deq_pc    = deq_valid ? r_pc_mem[r_rd_ptr]    : '0;
    assign deq_instr = deq_valid ? r_instr_mem[r_rd_ptr] : '0;
    assign count     = r_count;

endmodule
